// File: rtl/brick_pkg.sv
// Shared state encoding and colour helpers for the brick field.
package brick_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_LOWER,
    S_DRAW
  } state_t;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;

  function automatic logic [2:0] hits_to_colour(input logic [2:0] hits);
    logic [2:0] c;
    if (hits >= 3'd3)      c = GREEN;
    else if (hits == 3'd2) c = YELLOW;
    else if (hits == 3'd1) c = RED;
    else                   c = BLACK;
    return c;
  endfunction

endpackage

// File: rtl/brick_pixel_scan.sv
// Walks one block's pixels in raster order; a start on the last pixel chains the
// next block without a gap.
module brick_pixel_scan #(
  parameter int COORD_W = 8,
  parameter int BLOCK_W = 8,
  parameter int BLOCK_H = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_base_x,
  input  logic [COORD_W-1:0] i_base_y,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_plot,
  output logic               o_last
);

  localparam int NPIX  = BLOCK_W * BLOCK_H;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic               r_active;
  logic [CNT_W-1:0]   r_cnt;
  logic [COORD_W-1:0] r_bx, r_by;
  logic [31:0]        w_cnt;

  assign w_cnt  = 32'(r_cnt);
  assign o_plot = r_active;
  assign o_last = r_active && (r_cnt == CNT_W'(NPIX - 1));
  // BLOCK_W is a power of two, so these reduce to a bit split of the counter.
  assign o_x    = r_bx + COORD_W'(w_cnt % BLOCK_W);
  assign o_y    = r_by + COORD_W'(w_cnt / BLOCK_W);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bx     <= '0;
      r_by     <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_bx     <= i_base_x;
      r_by     <= i_base_y;
    end else if (r_active) begin
      if (o_last) r_active <= 1'b0;
      else        r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/brick_field.sv
// N-block, multi-hit brick field: init, collision query, lower, and pixel streaming
// driven by one-cycle commands from the game FSM.
module brick_field
  import brick_pkg::*;
#(
  parameter int NUM_BLOCKS = 5,
  parameter int COORD_W    = 8,
  parameter int BLOCK_W    = 8,
  parameter int BLOCK_H    = 2,
  parameter int X_START    = 15,
  parameter int X_PITCH    = 30,
  parameter int Y_START    = 30,
  parameter int LOWER_STEP = 10,
  parameter int FLOOR_Y    = 108,
  parameter int MAX_HITS   = 3,
  localparam int HI_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  input  logic               lower,
  input  logic               check_valid,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic               draw_start,
  output logic               busy,
  output logic               check_done,
  output logic               hit,
  output logic [HI_W-1:0]    hit_index,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [2:0]         colour,
  output logic               plot,
  output logic               draw_done,
  output logic               all_cleared,
  output logic               overrun
);

  localparam int IDX_W = $clog2(NUM_BLOCKS + 1);
  localparam logic [COORD_W:0] Y_MAX = {1'b0, {COORD_W{1'b1}}};

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [HI_W-1:0]    w_sidx, r_cur, r_fidx, r_hit_index;
  logic [COORD_W-1:0] r_bx   [NUM_BLOCKS];
  logic [COORD_W-1:0] r_by   [NUM_BLOCKS];
  logic [2:0]         r_hits [NUM_BLOCKS];
  logic [COORD_W-1:0] r_ball_x, r_ball_y;
  logic               r_found, r_hit, r_check_done, r_draw_done, r_overrun, r_any_left;
  logic               w_idle, w_acc_init, w_acc_lower, w_acc_check, w_acc_draw;
  logic               w_in_range, w_last_blk, w_blk_hit, w_any_left, w_over, w_scan_start;
  logic [COORD_W-1:0] w_sx, w_sy;
  logic               w_plot, w_last;

  assign w_idle      = (r_state == S_IDLE);
  assign w_acc_init  = w_idle && init;
  assign w_acc_lower = w_idle && !init && lower;
  assign w_acc_check = w_idle && !init && !lower && check_valid;
  assign w_acc_draw  = w_idle && !init && !lower && !check_valid && draw_start;

  assign w_sidx     = r_idx[HI_W-1:0];
  assign w_in_range = (r_idx < IDX_W'(NUM_BLOCKS));
  assign w_last_blk = (r_idx == IDX_W'(NUM_BLOCKS));

  // Bounds use one extra bit so a block near the top of the range never wraps.
  always_comb begin
    w_blk_hit = 1'b0;
    if (w_in_range && (r_hits[w_sidx] != 3'd0))
      w_blk_hit = (r_ball_x >= r_bx[w_sidx]) &&
                  ({1'b0, r_ball_x} <= ({1'b0, r_bx[w_sidx]} + (COORD_W+1)'(BLOCK_W - 1))) &&
                  (r_ball_y >= r_by[w_sidx]) &&
                  ({1'b0, r_ball_y} <= ({1'b0, r_by[w_sidx]} + (COORD_W+1)'(BLOCK_H - 1)));
  end

  always_comb begin
    w_any_left = 1'b0;
    w_over     = 1'b0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (r_hits[i] != 3'd0) begin
        w_any_left = 1'b1;
        if (({1'b0, r_by[i]} + (COORD_W+1)'(BLOCK_H - 1)) >= (COORD_W+1)'(FLOOR_Y))
          w_over = 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_scan_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc_init)       w_next = S_INIT;
        else if (w_acc_lower) w_next = S_LOWER;
        else if (w_acc_check) w_next = S_CHECK;
        else if (w_acc_draw)  w_next = S_DRAW;
      end
      S_INIT:  if (r_idx == IDX_W'(NUM_BLOCKS - 1)) w_next = S_IDLE;
      S_CHECK: if (w_last_blk) w_next = S_IDLE;
      S_LOWER: w_next = S_IDLE;
      S_DRAW: begin
        // r_idx is the next block to hand the scanner; chain on the last pixel.
        w_scan_start = !w_last_blk && (!w_plot || w_last);
        if (w_last_blk && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_cur        <= '0;
      r_fidx       <= '0;
      r_found      <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_index  <= '0;
      r_ball_x     <= '0;
      r_ball_y     <= '0;
      r_check_done <= 1'b0;
      r_draw_done  <= 1'b0;
      r_overrun    <= 1'b0;
      r_any_left   <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_bx[i]   <= '0;
        r_by[i]   <= '0;
        r_hits[i] <= '0;
      end
    end else begin
      r_check_done <= 1'b0;
      r_draw_done  <= 1'b0;
      r_any_left   <= w_any_left;
      if (w_acc_init || (r_state == S_INIT)) r_overrun <= 1'b0;
      else if (w_over)                       r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (w_acc_init) begin
            r_hit       <= 1'b0;
            r_hit_index <= '0;
          end
          if (w_acc_check) begin
            r_ball_x <= ball_x;
            r_ball_y <= ball_y;
            r_found  <= 1'b0;
            r_fidx   <= '0;
          end
        end
        S_INIT: begin
          r_bx[w_sidx]   <= COORD_W'(X_START + int'(r_idx) * X_PITCH);
          r_by[w_sidx]   <= COORD_W'(Y_START);
          r_hits[w_sidx] <= 3'(MAX_HITS);
          r_idx          <= r_idx + IDX_W'(1);
        end
        S_CHECK: begin
          if (!w_last_blk) begin
            if (w_blk_hit && !r_found) begin
              r_found <= 1'b1;
              r_fidx  <= w_sidx;
            end
            r_idx <= r_idx + IDX_W'(1);
          end else begin
            if (r_found) r_hits[r_fidx] <= r_hits[r_fidx] - 3'd1;
            r_hit        <= r_found;
            r_hit_index  <= r_fidx;
            r_check_done <= 1'b1;
          end
        end
        S_LOWER: begin
          for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (({1'b0, r_by[i]} + (COORD_W+1)'(LOWER_STEP)) > Y_MAX) r_by[i] <= '1;
            else r_by[i] <= r_by[i] + COORD_W'(LOWER_STEP);
          end
        end
        S_DRAW: begin
          if (w_scan_start) begin
            r_cur <= w_sidx;
            r_idx <= r_idx + IDX_W'(1);
          end
          if (w_last_blk && w_last) r_draw_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  brick_pixel_scan #(
    .COORD_W (COORD_W),
    .BLOCK_W (BLOCK_W),
    .BLOCK_H (BLOCK_H)
  ) u_scan (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_start  (w_scan_start),
    .i_base_x (r_bx[w_sidx]),
    .i_base_y (r_by[w_sidx]),
    .o_x      (w_sx),
    .o_y      (w_sy),
    .o_plot   (w_plot),
    .o_last   (w_last)
  );

  assign busy        = !w_idle;
  assign check_done  = r_check_done;
  assign hit         = r_hit;
  assign hit_index   = r_hit_index;
  assign plot        = w_plot;
  assign x           = w_plot ? w_sx : '0;
  assign y           = w_plot ? w_sy : '0;
  assign colour      = w_plot ? hits_to_colour(r_hits[r_cur]) : BLACK;
  assign draw_done   = r_draw_done;
  assign all_cleared = !r_any_left;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: a behavioural block model predicts query results
// and pixel streams; a negedge monitor pops and compares whatever the DUT presents.
module tb_brick_field;
  localparam int N = 5;

  logic       clock = 1'b0, reset = 1'b1;
  logic       init = 1'b0, lower = 1'b0, check_valid = 1'b0, draw_start = 1'b0;
  logic [7:0] ball_x = '0, ball_y = '0;
  logic       busy, check_done, hit, plot, draw_done, all_cleared, overrun;
  logic [2:0] hit_index, colour;
  logic [7:0] x, y;

  brick_field #(.NUM_BLOCKS(N)) dut (
    .clock(clock), .reset(reset), .init(init), .lower(lower),
    .check_valid(check_valid), .ball_x(ball_x), .ball_y(ball_y),
    .draw_start(draw_start), .busy(busy), .check_done(check_done),
    .hit(hit), .hit_index(hit_index), .x(x), .y(y), .colour(colour),
    .plot(plot), .draw_done(draw_done), .all_cleared(all_cleared),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  int errs = 0, checks = 0;
  int m_x[N], m_y[N], m_h[N];
  bit m_over;
  int n_dd;
  logic [31:0] q_chk[$], q_pix[$];
  int last_cyc, last_np, last_pf, last_pl;
  logic last_cd, last_dd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_colour(input int h);
    if (h >= 3) return 3'b010;
    if (h == 2) return 3'b110;
    if (h == 1) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] out_vec();
    return {3'b0, busy, check_done, hit, hit_index, x, y, colour, plot, draw_done, overrun, all_cleared};
  endfunction

  function automatic bit m_all_clear();
    for (int i = 0; i < N; i++) if (m_h[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_h[i] = 0; end
    m_over = 1'b0;
    n_dd = 0;
    q_chk.delete();
    q_pix.delete();
  endtask

  task automatic m_init();
    for (int i = 0; i < N; i++) begin m_x[i] = 15 + 30 * i; m_y[i] = 30; m_h[i] = 3; end
    m_over = 1'b0;
  endtask

  task automatic m_lower();
    for (int i = 0; i < N; i++) m_y[i] = (m_y[i] + 10 > 255) ? 255 : m_y[i] + 10;
    for (int i = 0; i < N; i++) if (m_h[i] != 0 && m_y[i] + 1 >= 108) m_over = 1'b1;
  endtask

  task automatic m_check(input int bx, input int by);
    int f;
    f = -1;
    for (int i = 0; i < N; i++)
      if (f < 0 && m_h[i] != 0 && by >= m_y[i] && by <= m_y[i] + 1 && bx >= m_x[i] && bx <= m_x[i] + 7)
        f = i;
    if (f >= 0) begin
      m_h[f]--;
      q_chk.push_back(32'(8 + f));
    end else begin
      q_chk.push_back(32'd0);
    end
  endtask

  task automatic m_draw();
    for (int i = 0; i < N; i++)
      for (int c = 0; c < 16; c++)
        q_pix.push_back((32'((m_x[i] + c % 8) % 256) << 16) | (32'((m_y[i] + c / 8) % 256) << 8) |
                        32'(ref_colour(m_h[i])));
    n_dd++;
  endtask

  // Monitor: compare every presented result against the head of its queue.
  always @(negedge clock) begin
    logic [31:0] e;
    if (check_done) begin
      if (q_chk.size() == 0) begin
        checks++; errs++;
        $display("FAIL check_unexpected: got check_done hit=%0b idx=%0d, required no pulse", hit, hit_index);
      end else begin
        e = q_chk.pop_front();
        chk("check_result", 32'({hit, hit_index}), e);
      end
    end
    if (plot) begin
      if (q_pix.size() == 0) begin
        checks++; errs++;
        $display("FAIL plot_unexpected: got pixel (%0d,%0d), required no plot", x, y);
      end else begin
        e = q_pix.pop_front();
        chk("pixel", {8'h0, x, y, 5'h0, colour}, e);
      end
    end
    if (draw_done) begin
      if (n_dd == 0) begin
        checks++; errs++;
        $display("FAIL draw_done_unexpected: got pulse, required none");
      end else begin
        n_dd--;
        chk("done_plot_low", 32'(plot), 32'd0);
        chk("pixels_left", 32'(q_pix.size()), 32'd0);
      end
    end
  end

  // Called on a negedge with the DUT idle; returns on a negedge after completion.
  task automatic issue(input bit ii, input bit il, input bit ic, input bit id,
                       input logic [7:0] bx, input logic [7:0] by, input bit midchk);
    init = ii; lower = il; check_valid = ic; draw_start = id; ball_x = bx; ball_y = by;
    if (ii)      m_init();
    else if (il) m_lower();
    else if (ic) m_check(int'(bx), int'(by));
    else if (id) m_draw();
    @(negedge clock);
    init = 1'b0; lower = 1'b0; check_valid = 1'b0; draw_start = 1'b0;
    last_cyc = 0; last_np = 0; last_pf = -1; last_pl = -1;
    while (busy && last_cyc < 500) begin
      if (plot) begin
        last_np++;
        if (last_pf < 0) last_pf = last_cyc;
        last_pl = last_cyc;
      end
      check_valid = midchk && (last_cyc == 20);
      @(negedge clock);
      last_cyc++;
    end
    check_valid = 1'b0;
    chk("busy_bounded", 32'(busy), 32'd0);
    last_cd = check_done;
    last_dd = draw_done;
    @(negedge clock);
    chk("all_cleared", 32'(all_cleared), 32'(m_all_clear()));
    chk("overrun", 32'(overrun), 32'(m_over));
  endtask

  initial begin
    bit ii, il, ic, id;
    int b;
    logic [7:0] bx, by;
    m_reset();
    repeat (2) @(negedge clock);
    chk("reset_outputs", out_vec(), 32'h1);
    reset = 1'b0;
    @(negedge clock);

    issue(1, 0, 0, 0, 8'd0, 8'd0, 0);
    chk("init_busy_cycles", 32'(last_cyc), 32'd5);
    chk("blk3_x", 32'(dut.r_bx[3]), 32'd105);
    chk("blk3_y", 32'(dut.r_by[3]), 32'd30);
    chk("blk3_hits", 32'(dut.r_hits[3]), 32'd3);

    issue(0, 0, 1, 0, 8'd20, 8'd31, 0);
    chk("check_latency", 32'(last_cyc), 32'd6);
    chk("check_done_at_idle", 32'(last_cd), 32'd1);
    chk("blk0_hits", 32'(dut.r_hits[0]), 32'd2);
    issue(0, 0, 1, 0, 8'd0, 8'd0, 0);

    for (int k = 0; k < 3; k++) begin
      issue(0, 0, 0, 1, 8'd0, 8'd0, 0);
      issue(0, 0, 1, 0, 8'd75, 8'd30, 0);
    end
    issue(0, 0, 1, 0, 8'd75, 8'd30, 0);
    issue(0, 0, 0, 1, 8'd0, 8'd0, 0);

    for (int k = 0; k < 8; k++) begin
      issue(0, 1, 0, 0, 8'd0, 8'd0, 0);
      chk("lower_cycles", 32'(last_cyc), 32'd1);
    end
    chk("overrun_after8", 32'(overrun), 32'd1);
    issue(1, 0, 0, 0, 8'd0, 8'd0, 0);

    issue(0, 0, 0, 1, 8'd0, 8'd0, 1);
    chk("draw_plot_count", 32'(last_np), 32'd80);
    chk("draw_first_plot", 32'(last_pf), 32'd1);
    chk("draw_contiguous", 32'(last_pl - last_pf + 1), 32'd80);
    chk("draw_done_at_idle", 32'(last_dd), 32'd1);
    chk("draw_cycles", 32'(last_cyc), 32'd81);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++)
        issue(0, 0, 1, 0, 8'(m_x[i] + 3), 8'(m_y[i] + 1), 0);
    issue(0, 0, 0, 1, 8'd0, 8'd0, 0);

    issue(1, 0, 0, 0, 8'd0, 8'd0, 0);
    for (int it = 0; it < 60; it++) begin
      ii = ($urandom_range(0, 9) == 0);
      il = ($urandom_range(0, 4) == 0) && (m_y[0] < 200);
      ic = ($urandom_range(0, 1) == 1);
      id = ($urandom_range(0, 3) == 0);
      b  = $urandom_range(0, N - 1);
      if ($urandom_range(0, 4) == 0) begin
        bx = 8'($urandom_range(0, 255));
        by = 8'($urandom_range(0, 255));
      end else begin
        bx = 8'(m_x[b] + $urandom_range(0, 9) - 1);
        by = 8'(m_y[b] + $urandom_range(0, 3) - 1);
      end
      issue(ii, il, ic, id, bx, by, 0);
    end

    issue(1, 0, 0, 0, 8'd0, 8'd0, 0);
    check_valid = 1'b1; ball_x = 8'd20; ball_y = 8'd30;
    @(negedge clock);
    check_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    #1 chk("reset_mid_check", out_vec(), 32'h1);
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    issue(1, 0, 0, 0, 8'd0, 8'd0, 0);
    draw_start = 1'b1;
    m_draw();
    @(negedge clock);
    draw_start = 1'b0;
    repeat (10) @(negedge clock);
    #1 reset = 1'b1;
    #1 chk("reset_mid_draw", out_vec(), 32'h1);
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    chk("idle_after_reset", 32'(busy), 32'd0);

    chk("check_queue_drained", 32'(q_chk.size()), 32'd0);
    chk("pixel_queue_drained", 32'(q_pix.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
